// File: rtl/mult_issue_ctrl_pkg.sv
// Shared widths, multiplier timing and FSM state encoding for the
// multiplier issue/collect stage.
package mult_issue_ctrl_pkg;

  localparam int MUL_A_W     = 8;
  localparam int MUL_B_W     = 24;
  localparam int MUL_Y_W     = 24;
  localparam int MUL_LATENCY = 26;
  localparam int REQ_W       = MUL_A_W + MUL_B_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_req_fifo.sv
// Request FIFO: {b,a} entries, pointers one bit wider than the address so
// full and empty can be told apart without a separate occupancy counter.
module mult_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wptr_q <= wptr_q + 1'b1;
      if (pop_i  && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/collect stage for the sequential 8x24 multiplier: buffers requests,
// issues one at a time, captures the product or a timeout error.
module mult_issue_ctrl
  import mult_issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [MUL_A_W-1:0] req_a_i,
  input  logic [MUL_B_W-1:0] req_b_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [MUL_Y_W-1:0] res_y_o,
  output logic               res_err_o,
  output logic               mul_start_o,
  output logic [MUL_A_W-1:0] mul_a_o,
  output logic [MUL_B_W-1:0] mul_b_o,
  input  logic               mul_busy_i,
  input  logic [MUL_Y_W-1:0] mul_y_i
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [MUL_A_W-1:0] mulA_q, mulA_d;
  logic [MUL_B_W-1:0] mulB_q, mulB_d;
  logic               resValid_q, resValid_d;
  logic [MUL_Y_W-1:0] resY_q, resY_d;
  logic               resErr_q, resErr_d;

  logic               fifoPush;
  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [REQ_W-1:0]   fifoHead;
  logic               startPulse;

  assign fifoPush    = req_valid_i && !fifoFull;
  assign req_ready_o = !fifoFull;

  mult_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i ({req_b_i, req_a_i}),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Operands are latched on the way into ISSUE so they are already stable
  // during the start pulse and stay put until the next issue.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mulA_d     = mulA_q;
    mulB_d     = mulB_q;
    resValid_d = resValid_q;
    resY_d     = resY_q;
    resErr_d   = resErr_q;
    fifoPop    = 1'b0;
    startPulse = 1'b0;

    if (resValid_q && res_ready_i) resValid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty && !resValid_q && !mul_busy_i) begin
          state_d = ISSUE;
          mulA_d  = fifoHead[MUL_A_W-1:0];
          mulB_d  = fifoHead[REQ_W-1:MUL_A_W];
        end
      end
      ISSUE: begin
        startPulse = 1'b1;
        fifoPop    = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (!mul_busy_i) begin
          resY_d     = mul_y_i;
          resErr_d   = 1'b0;
          resValid_d = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resY_d     = '0;
          resErr_d   = 1'b1;
          resValid_d = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      resValid_q <= 1'b0;
      resY_q     <= '0;
      resErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      resValid_q <= resValid_d;
      resY_q     <= resY_d;
      resErr_q   <= resErr_d;
    end
  end

  assign mul_start_o = startPulse;
  assign mul_a_o     = mulA_q;
  assign mul_b_o     = mulB_q;
  assign res_valid_o = resValid_q;
  assign res_y_o     = resY_q;
  assign res_err_o   = resErr_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl with a behavioural shift-add
// multiplier back end (26-cycle busy window, optional stuck-busy fault).
module tb_mult_issue_ctrl;
  import mult_issue_ctrl_pkg::*;

  localparam int TIMEOUT_TB = 32;

  typedef struct packed {
    logic [23:0] y;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        mulRstN;
  logic        reqValid;
  logic        reqReady;
  logic [7:0]  reqA;
  logic [23:0] reqB;
  logic        resValid;
  logic        resReady;
  logic [23:0] resY;
  logic        resErr;
  logic        mulStart;
  logic [7:0]  mulA;
  logic [23:0] mulB;
  logic        mulBusy;
  logic [23:0] mulY;

  logic [4:0]  mulCnt;
  logic [7:0]  opA;
  logic [23:0] opB;
  logic [31:0] mulProd;
  logic        stuckBusy;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   cyc = 0;
  int   startCount = 0;
  int   startCyc = 0;
  int   riseCyc = 0;
  int   startWhileBusy = 0;
  logic resValidPrev = 1'b0;

  mult_issue_ctrl #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (TIMEOUT_TB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_a_i     (reqA),
    .req_b_i     (reqB),
    .res_valid_o (resValid),
    .res_ready_i (resReady),
    .res_y_o     (resY),
    .res_err_o   (resErr),
    .mul_start_o (mulStart),
    .mul_a_o     (mulA),
    .mul_b_o     (mulB),
    .mul_busy_i  (mulBusy),
    .mul_y_i     (mulY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: busy during the start cycle plus 25 following cycles.
  assign mulProd = {24'b0, opA} * {8'b0, opB};
  assign mulBusy = stuckBusy | mulStart | (mulCnt != 5'd0);

  always @(posedge clk or negedge mulRstN) begin
    if (!mulRstN) begin
      mulCnt <= 5'd0;
      opA    <= 8'd0;
      opB    <= 24'd0;
      mulY   <= 24'd0;
    end else if (mulStart) begin
      mulCnt <= 5'd25;
      opA    <= mulA;
      opB    <= mulB;
    end else if (mulCnt != 5'd0) begin
      mulCnt <= mulCnt - 5'd1;
      if (mulCnt == 5'd1) mulY <= mulProd[23:0];
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mulStart) begin
      startCount = startCount + 1;
      startCyc   = cyc;
      if (mulCnt != 5'd0 || stuckBusy) startWhileBusy = startWhileBusy + 1;
    end
    if (resValid && !resValidPrev) riseCyc = cyc;
    resValidPrev = resValid;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushOp(input logic [7:0] a, input logic [23:0] b,
                        input bit expErr, input bit score);
    bit          done;
    exp_t        e;
    logic [31:0] p;
    done     = 1'b0;
    reqA     = a;
    reqB     = b;
    reqValid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      if (reqReady) begin
        done = 1'b1;
        if (score) begin
          p     = {24'b0, a} * {8'b0, b};
          e.y   = expErr ? 24'd0 : p[23:0];
          e.err = expErr;
          expQ.push_back(e);
        end
      end
      @(negedge clk);
    end
    reqValid = 1'b0;
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL push_accept: req_ready never 1 (got 0, required 1)");
    end
  endtask

  task automatic waitValid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (resValid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitStart(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mulStart) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0; mulRstN = 1'b0; reqValid = 1'b0; resReady = 1'b0;
    stuckBusy = 1'b0; reqA = 8'd0; reqB = 24'd0;
    #3;
    testsRun++;
    if (resValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b required 0", resValid); end
    testsRun++;
    if (resY !== 24'd0 || resErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_result: got y=%h err=%b required 0/0", resY, resErr); end
    testsRun++;
    if (mulStart !== 1'b0 || mulA !== 8'd0 || mulB !== 24'd0) begin testsFailed++; $display("[TB] FAIL reset_mul: got start=%b a=%h b=%h required 0", mulStart, mulA, mulB); end
    testsRun++;
    if (reqReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b required 1", reqReady); end
    repeat (3) @(negedge clk);
    rstN = 1'b1; mulRstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit   seen;
    exp_t e;
    int   snap;
    resReady = 1'b1;
    snap = startCount;
    pushOp(8'd3, 24'd5, 1'b0, 1'b1);
    waitValid(seen);
    testsRun++;
    if (!seen || expQ.size() == 0) begin
      testsFailed++; $display("[TB] FAIL single_valid: no result (got 0, required 1)");
    end else begin
      e = expQ.pop_front();
      testsRun++;
      if (resY !== e.y || resY !== 24'd15) begin testsFailed++; $display("[TB] FAIL single_y: got %0d required %0d", resY, e.y); end
      testsRun++;
      if (resErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_err: got %b required 0", resErr); end
    end
    @(negedge clk);
    testsRun++;
    if (startCount - snap != 1) begin testsFailed++; $display("[TB] FAIL single_starts: got %0d required 1", startCount - snap); end
    testsRun++;
    if (riseCyc - startCyc != MUL_LATENCY + 1) begin testsFailed++; $display("[TB] FAIL single_latency: got %0d required %0d", riseCyc - startCyc, MUL_LATENCY + 1); end
  endtask

  task automatic test_overflow;
    logic [7:0]  aTab [3];
    logic [23:0] bTab [3];
    bit          seen;
    exp_t        e;
    aTab = '{8'hFF, 8'h00, 8'h5A};
    bTab = '{24'hFFFFFF, 24'h123456, 24'h000000};
    resReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pushOp(aTab[k], bTab[k], 1'b0, 1'b1);
      waitValid(seen);
      testsRun++;
      if (!seen || expQ.size() == 0) begin
        testsFailed++; $display("[TB] FAIL overflow_valid[%0d]: no result (got 0, required 1)", k);
      end else begin
        e = expQ.pop_front();
        testsRun++;
        if (resY !== e.y || resErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL overflow_y[%0d]: got y=%h err=%b required y=%h err=0", k, resY, resErr, e.y); end
        if (k == 0) begin
          testsRun++;
          if (resY !== 24'hFFFF01) begin testsFailed++; $display("[TB] FAIL overflow_wrap: got %h required FFFF01", resY); end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    bit   seen;
    exp_t e;
    int   snap;
    resReady = 1'b0;
    snap = startCount;
    pushOp(8'h11, 24'h000101, 1'b0, 1'b1);
    waitValid(seen);
    pushOp(8'h02, 24'h000003, 1'b0, 1'b1);
    pushOp(8'h10, 24'h010000, 1'b0, 1'b1);
    pushOp(8'h80, 24'h123456, 1'b0, 1'b1);
    pushOp(8'hC3, 24'hABCDEF, 1'b0, 1'b1);
    testsRun++;
    if (reqReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_full: got ready=%b required 0", reqReady); end
    testsRun++;
    if (startCount - snap != 1) begin testsFailed++; $display("[TB] FAIL b2b_held: got %0d starts required 1", startCount - snap); end
    resReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitValid(seen);
      testsRun++;
      if (!seen || expQ.size() == 0) begin
        testsFailed++; $display("[TB] FAIL b2b_valid[%0d]: no result (got 0, required 1)", k);
      end else begin
        e = expQ.pop_front();
        if (resY !== e.y || resErr !== e.err) begin testsFailed++; $display("[TB] FAIL b2b_y[%0d]: got %h/%b required %h/%b", k, resY, resErr, e.y, e.err); end
      end
      @(negedge clk);
    end
    testsRun++;
    if (startCount - snap != 5) begin testsFailed++; $display("[TB] FAIL b2b_starts: got %0d required 5", startCount - snap); end
    testsRun++;
    if (startWhileBusy != 0) begin testsFailed++; $display("[TB] FAIL b2b_start_busy: got %0d required 0", startWhileBusy); end
  endtask

  task automatic test_timeout;
    bit   seen;
    exp_t e;
    resReady = 1'b0;
    pushOp(8'd7, 24'd7, 1'b1, 1'b1);
    waitStart(seen);
    stuckBusy = 1'b1;
    testsRun++;
    if (!seen) begin testsFailed++; $display("[TB] FAIL timeout_issue: got no start required 1"); end
    waitValid(seen);
    testsRun++;
    if (!seen || expQ.size() == 0) begin
      testsFailed++; $display("[TB] FAIL timeout_valid: no result (got 0, required 1)");
    end else begin
      e = expQ.pop_front();
      if (resY !== e.y || resErr !== e.err) begin testsFailed++; $display("[TB] FAIL timeout_err: got y=%h err=%b required y=%h err=%b", resY, resErr, e.y, e.err); end
    end
    @(negedge clk);
    testsRun++;
    if (riseCyc - startCyc != TIMEOUT_TB + 1) begin testsFailed++; $display("[TB] FAIL timeout_latency: got %0d required %0d", riseCyc - startCyc, TIMEOUT_TB + 1); end
    stuckBusy = 1'b0;
    resReady  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit          seen;
    exp_t        e;
    int          snapS;
    int          unstable;
    logic [23:0] y0;
    logic        err0;
    resReady = 1'b0;
    pushOp(8'h21, 24'h000345, 1'b0, 1'b1);
    pushOp(8'h0F, 24'h00F00F, 1'b0, 1'b1);
    waitValid(seen);
    y0 = resY; err0 = resErr; snapS = startCount; unstable = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!resValid || resY !== y0 || resErr !== err0) unstable++;
    end
    testsRun++;
    if (unstable != 0) begin testsFailed++; $display("[TB] FAIL bp_stable: got %0d changes required 0", unstable); end
    testsRun++;
    if (startCount != snapS) begin testsFailed++; $display("[TB] FAIL bp_no_start: got %0d starts required 0", startCount - snapS); end
    testsRun++;
    if (!seen || expQ.size() == 0) begin
      testsFailed++; $display("[TB] FAIL bp_valid1: no result (got 0, required 1)");
    end else begin
      e = expQ.pop_front();
      if (resY !== e.y || resErr !== e.err) begin testsFailed++; $display("[TB] FAIL bp_y1: got %h required %h", resY, e.y); end
    end
    resReady = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6 && startCount == snapS; i++) @(negedge clk);
    testsRun++;
    if (startCount - snapS != 1) begin testsFailed++; $display("[TB] FAIL bp_reissue: got %0d starts required 1", startCount - snapS); end
    waitValid(seen);
    testsRun++;
    if (!seen || expQ.size() == 0) begin
      testsFailed++; $display("[TB] FAIL bp_valid2: no result (got 0, required 1)");
    end else begin
      e = expQ.pop_front();
      if (resY !== e.y || resErr !== e.err) begin testsFailed++; $display("[TB] FAIL bp_y2: got %h required %h", resY, e.y); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    bit   seen;
    exp_t e;
    resReady = 1'b1;
    pushOp(8'd9, 24'd9, 1'b0, 1'b0);
    waitStart(seen);
    repeat (10) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    testsRun++;
    if (resValid !== 1'b0 || resY !== 24'd0 || resErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_res: got v=%b y=%h e=%b required 0", resValid, resY, resErr); end
    testsRun++;
    if (mulStart !== 1'b0 || mulA !== 8'd0 || mulB !== 24'd0 || reqReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_mid_mul: got s=%b a=%h b=%h rdy=%b required 0/0/0/1", mulStart, mulA, mulB, reqReady); end
    mulRstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1; mulRstN = 1'b1;
    @(negedge clk);
    pushOp(8'd2, 24'd7, 1'b0, 1'b1);
    waitValid(seen);
    testsRun++;
    if (!seen || expQ.size() == 0) begin
      testsFailed++; $display("[TB] FAIL rst_mid_valid: no result (got 0, required 1)");
    end else begin
      e = expQ.pop_front();
      if (resY !== e.y || resY !== 24'd14 || resErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_y: got %0d required 14", resY); end
    end
    @(negedge clk);
    testsRun++;
    if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL scoreboard_empty: got %0d left required 0", expQ.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
